// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode
// seven-segment display. Hex nibbles are decoded to active-low segments and
// each digit is lit in turn, preceded by an all-off blanking gap. New data is
// written through a valid/ready port into a shadow register and only becomes
// visible at a frame boundary, so a frame never mixes old and new values.
//
// Optional build macro: SEG7_SCAN_LZB_EN enables leading-zero blanking.
//
// state | meaning
// ------+---------------------------------------------------------------
// BLANK | all digits and segments off for GAP_CYC clocks before a digit
// SHOW  | digit idx lit with its decoded nibble for TICK_DIV clocks
module seg7_scan_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int GAP_CYC  = 8,
    parameter int N_DIGITS = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    output logic        wr_ready,
    output logic [7:0]  an,
    output logic [6:0]  a_to_g,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_MAX = (TICK_DIV > GAP_CYC) ? TICK_DIV : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(N_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             boundary;

    logic             pending;
    logic [31:0]      shadow_data;
    logic [7:0]       shadow_dp;
    logic [31:0]      active_data;
    logic [7:0]       active_dp;
    logic             accept;
    logic             commit;

    logic [7:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;
    logic             lit;

    // Hex nibble to active-low abcdefg pattern (bit 6 = a).
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

`ifdef SEG7_SCAN_LZB_EN
    // Index of the most significant nonzero nibble; 0 when all are zero so
    // digit 0 always stays lit.
    function automatic logic [2:0] msnz(input logic [31:0] data);
        logic [2:0] top;
        top = 3'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (data[i*4 +: 4] != 4'h0) begin
                top = 3'(i);
            end
        end
        return top;
    endfunction
`endif

    assign wr_ready = ~pending;
    assign accept   = wr_en & ~pending;
    assign commit   = boundary & pending;

    // Scan sequencing: slot timer, digit index and frame boundary detect.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        boundary  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (idx == LAST_IDX) begin
                        idx_nxt  = 3'd0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                idx_nxt   = 3'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Display outputs for the upcoming state; registered below so they switch
    // on the same edge as the state. SHOW is never entered on a commit edge,
    // so the current active registers are the ones to display.
    always_comb begin
        an_nxt  = 8'hFF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        lit     = 1'b1;
`ifdef SEG7_SCAN_LZB_EN
        lit     = (idx_nxt <= msnz(active_data));
`endif
        if (state_nxt == ST_SHOW && lit) begin
            an_nxt[idx_nxt] = 1'b0;
            seg_nxt         = decode(active_data[idx_nxt*4 +: 4]);
            dp_nxt          = ~active_dp[idx_nxt];
        end
    end

    // Scan state, slot timer and registered display outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_BLANK;
            idx        <= 3'd0;
            cnt        <= '0;
            an         <= 8'hFF;
            a_to_g     <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            an         <= an_nxt;
            a_to_g     <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= boundary;
        end
    end

    // Shadow capture on handshake; shadow moves to active only at a frame
    // boundary. A write accepted on the boundary edge itself waits a frame.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending     <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
        end else begin
            if (commit) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end else if (accept) begin
                shadow_data <= wr_data;
                shadow_dp   <= wr_dp;
                pending     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a short scan (TICK_DIV=4, GAP_CYC=1, 8 digits).
// Stimulus pushes the expected {an, a_to_g, dp} of every lit slot of each frame
// into a queue; a monitor pops one entry at the start of each lit slot.
module tb_seg7_scan_ctrl;

    localparam int TICK = 4;
    localparam int GAP  = 1;
    localparam int ND   = 8;
    localparam int FRAME = ND * (TICK + GAP);

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;
    logic        wr_ready;
    logic [7:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b1;
    logic [15:0] sb[$];

    logic [6:0] dec [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_ctrl #(
        .TICK_DIV (TICK),
        .GAP_CYC  (GAP),
        .N_DIGITS (ND)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_ready   (wr_ready),
        .an         (an),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) got = 1'b1;
        end
        check("frame_wait", {31'd0, got}, 32'd1);
    endtask

    // Expected lit slots of one frame showing data/dpv.
    task automatic push_frame(input logic [31:0] data, input logic [7:0] dpv);
        int top;
        top = ND - 1;
`ifdef SEG7_SCAN_LZB_EN
        top = 0;
        for (int i = 0; i < ND; i++) if (data[i*4 +: 4] != 4'h0) top = i;
`endif
        for (int i = 0; i <= top; i++) begin
            logic [7:0] a;
            logic [3:0] nib;
            a = 8'hFF;
            a[i] = 1'b0;
            nib = data[i*4 +: 4];
            sb.push_back({a, dec[nib], ~dpv[i]});
        end
    endtask

    // Monitor: slot pops, slot/gap lengths and frame_done spacing.
    initial begin
        logic [7:0] prev_an;
        int run;
        bit first;
        int fd_cnt;
        bit fd_seen;
        logic [15:0] exp;
        prev_an = 8'hFF;
        run = 0;
        first = 1'b1;
        fd_cnt = 0;
        fd_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (clr) begin
                prev_an = 8'hFF;
                run = 0;
                first = 1'b1;
                fd_seen = 1'b0;
                fd_cnt = 0;
            end else begin
                fd_cnt++;
                if (frame_done) begin
                    if (fd_seen) check("fd_period", fd_cnt, FRAME);
                    fd_seen = 1'b1;
                    fd_cnt = 0;
                end
                if (an !== prev_an) begin
`ifndef SEG7_SCAN_LZB_EN
                    if (!first) begin
                        if (prev_an == 8'hFF) check("blank_len", run, GAP);
                        else check("show_len", run, TICK);
                    end
`endif
                    first = 1'b0;
                    if (an != 8'hFF && mon_en) begin
                        if (sb.size() == 0) begin
                            check("sb_empty", {16'd0, an, a_to_g, dp}, 32'hFFFF_FFFF);
                        end else begin
                            exp = sb.pop_front();
                            check("slot", {16'd0, an, a_to_g, dp}, {16'd0, exp});
                        end
                    end
                    run = 1;
                    prev_an = an;
                end else begin
                    run++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        wait_cyc(3);
        check("rst_an", {24'd0, an}, 32'h0000_00FF);
        check("rst_seg", {25'd0, a_to_g}, 32'h0000_007F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        push_frame(32'h0000_0000, 8'h00);
        clr = 1'b0;

        // Write during the first frame, then a dropped write while busy.
        wait_cyc(2);
        wr_en = 1'b1;
        wr_data = 32'h0123_4567;
        wr_dp = 8'h01;
        wait_cyc(1);
        wr_en = 1'b0;
        check("ready_fall", {31'd0, wr_ready}, 32'd0);
        wr_en = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        wr_dp = 8'hFF;
        wait_cyc(2);
        wr_en = 1'b0;
        check("ready_busy", {31'd0, wr_ready}, 32'd0);

        wait_frame();
        push_frame(32'h0123_4567, 8'h01);
        check("ready_back", {31'd0, wr_ready}, 32'd1);

        // Write accepted exactly on the boundary edge: must wait one frame.
        wait_cyc(FRAME - 1);
        wr_en = 1'b1;
        wr_data = 32'h89AB_CDEF;
        wr_dp = 8'h80;
        wait_cyc(1);
        wr_en = 1'b0;
        check("bnd_fd", {31'd0, frame_done}, 32'd1);
        check("bnd_pending", {31'd0, wr_ready}, 32'd0);
        push_frame(32'h0123_4567, 8'h01);

        wait_frame();
        push_frame(32'h89AB_CDEF, 8'h80);
        check("bnd_commit", {31'd0, wr_ready}, 32'd1);

        // Reset in the middle of digit 3's SHOW.
        wait_cyc(3 * (TICK + GAP) + 1);
        check("d3_an", {24'd0, an}, 32'h0000_00F7);
        check("d3_seg", {25'd0, a_to_g}, 32'h0000_0031);
        wait_cyc(1);
        clr = 1'b1;
        #1;
        check("clr_an", {24'd0, an}, 32'h0000_00FF);
        check("clr_seg", {25'd0, a_to_g}, 32'h0000_007F);
        check("clr_dp", {31'd0, dp}, 32'd1);
        check("clr_ready", {31'd0, wr_ready}, 32'd1);
        sb.delete();
        push_frame(32'h0000_0000, 8'h00);
        wait_cyc(2);
        clr = 1'b0;
        wait_cyc(GAP);
        check("restart_an", {24'd0, an}, 32'h0000_00FE);
        check("restart_seg", {25'd0, a_to_g}, 32'h0000_0001);

        // Data with leading zeros.
        wr_en = 1'b1;
        wr_data = 32'h0000_00A0;
        wr_dp = 8'h00;
        wait_cyc(1);
        wr_en = 1'b0;
        wait_frame();
        push_frame(32'h0000_00A0, 8'h00);
        wait_frame();
        mon_en = 1'b0;
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
